// File: rtl/ad80305_tx_sched.sv
// TX sequencing and source arbitration for the AD80305 LVCMOS DDR path.
// Drives the TX clock-crossing FIFO write side: bring-up, pacing and FIFO error recovery.
module ad80305_tx_sched #(
   parameter int RATE_DIV   = 4,
   parameter int FLUSH_CYC  = 8,
   parameter int SETTLE_CYC = 64,
   parameter int PREFILL    = 4
) (
   input  logic        i_fpga_clk,
   input  logic        i_fpga_rst,
   input  logic        i_tx_en,
   input  logic [1:0]  i_src_sel,
   input  logic [11:0] i_bb_idata,
   input  logic [11:0] i_bb_qdata,
   input  logic        i_fifo_wrfull,
   input  logic        i_fifo_rdempty,
   output logic        o_fifo_aclr,
   output logic        o_fifo_wrreq,
   output logic [23:0] o_fifo_data,
   output logic [2:0]  o_state,
   output logic        o_running,
   output logic [15:0] o_ovf_cnt,
   output logic [15:0] o_unf_cnt
);

   localparam int DATA_W = 12;

   localparam logic [3:0] PACE_LAST    = 4'(RATE_DIV - 1);
   localparam logic [9:0] FLUSH_LAST   = 10'(FLUSH_CYC - 1);
   localparam logic [9:0] SETTLE_LAST  = 10'(SETTLE_CYC - 1);
   localparam logic [9:0] PREFILL_LAST = 10'(PREFILL - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FLUSH   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_PREFILL = 3'd3,
      ST_RUN     = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [3:0]  pace;
   logic [9:0]  seq_cnt;
   logic [11:0] ramp;
   logic        rdempty_p0, rdempty_p1, rdempty_p2;
   logic [15:0] ovf_cnt, unf_cnt;
   logic        aclr, wrreq, running;
   logic [23:0] data;

   logic        active, strobe, write, ovf_evt, unf_evt, ramp_wr;
   logic signed [DATA_W-1:0] word_i, word_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign active  = (state == ST_PREFILL) || (state == ST_RUN);
   assign strobe  = active && (pace == PACE_LAST);
   assign ovf_evt = strobe && i_fifo_wrfull;
   assign unf_evt = (state == ST_RUN) && rdempty_p1 && !rdempty_p2;
   assign write   = strobe && !i_fifo_wrfull && i_tx_en;
   assign ramp_wr = write && (i_src_sel == 2'd1);

   always_comb begin
      word_i = '0;
      word_q = '0;
      case (i_src_sel)
         2'd0: begin
            word_i = i_bb_idata;
            word_q = i_bb_qdata;
         end
         2'd1: begin
            word_i = ramp;
            word_q = ~ramp;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    state_nxt = ST_FLUSH;
         ST_FLUSH:   if (seq_cnt == FLUSH_LAST) state_nxt = ST_SETTLE;
         ST_SETTLE:  if (seq_cnt == SETTLE_LAST) state_nxt = ST_PREFILL;
         ST_PREFILL: begin
            if (ovf_evt)
               state_nxt = ST_FLUSH;
            else if (write && (seq_cnt == PREFILL_LAST))
               state_nxt = ST_RUN;
         end
         ST_RUN:     if (ovf_evt || unf_evt) state_nxt = ST_FLUSH;
         default:    state_nxt = ST_IDLE;
      endcase
      // disable wins over every other transition
      if (!i_tx_en)
         state_nxt = ST_IDLE;
   end

   always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
      if (!i_fpga_rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // p0/p1 synchronise the read-side empty flag, p2 holds the previous sample for edge detect
   always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
      if (!i_fpga_rst) begin
         rdempty_p0 <= 1'b1;
         rdempty_p1 <= 1'b1;
         rdempty_p2 <= 1'b1;
      end else begin
         rdempty_p0 <= i_fifo_rdempty;
         rdempty_p1 <= rdempty_p0;
         rdempty_p2 <= rdempty_p1;
      end
   end

   always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
      if (!i_fpga_rst) begin
         seq_cnt <= '0;
         pace    <= '0;
         ramp    <= '0;
         wrreq   <= 1'b0;
         data    <= '0;
         aclr    <= 1'b1;
         running <= 1'b0;
         ovf_cnt <= '0;
         unf_cnt <= '0;
      end else begin
         if (state_nxt != state)
            seq_cnt <= '0;
         else if ((state == ST_FLUSH) || (state == ST_SETTLE) || ((state == ST_PREFILL) && write))
            seq_cnt <= seq_cnt + 10'd1;

         if (active && ((state_nxt == ST_PREFILL) || (state_nxt == ST_RUN)))
            pace <= (pace == PACE_LAST) ? 4'd0 : pace + 4'd1;
         else
            pace <= '0;

         if ((state_nxt == ST_FLUSH) && (state != ST_FLUSH))
            ramp <= '0;
         else if (ramp_wr)
            ramp <= ramp + 12'd1;

         wrreq <= write;
         if (write)
            data <= {word_q, word_i};

         aclr    <= (state_nxt == ST_IDLE) || (state_nxt == ST_FLUSH);
         running <= (state_nxt == ST_RUN);

         ovf_cnt <= ovf_evt ? sat_inc(ovf_cnt) : ovf_cnt;
         unf_cnt <= unf_evt ? sat_inc(unf_cnt) : unf_cnt;
      end
   end

   assign o_fifo_aclr  = aclr;
   assign o_fifo_wrreq = wrreq;
   assign o_fifo_data  = data;
   assign o_state      = state;
   assign o_running    = running;
   assign o_ovf_cnt    = ovf_cnt;
   assign o_unf_cnt    = unf_cnt;

endmodule

// File: tb/tb_ad80305_tx_sched.sv
// Bench for ad80305_tx_sched: directed bring-up/recovery steps with randomized IQ and source traffic.
module tb_ad80305_tx_sched;

   localparam int RATE_DIV   = 4;
   localparam int FLUSH_CYC  = 8;
   localparam int SETTLE_CYC = 64;
   localparam int PREFILL    = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tx_en = 1'b0;
   logic [1:0]  src = 2'd0;
   logic [11:0] bi = 12'd0;
   logic [11:0] bq = 12'd0;
   logic        wrfull = 1'b0;
   logic        rdempty = 1'b0;
   logic        aclr, wrreq, running;
   logic [23:0] data;
   logic [2:0]  st;
   logic [15:0] ovf, unf;

   int          checks = 0;
   int          errors = 0;
   logic [11:0] m_ramp = 12'd0;

   always #5 clk = ~clk;

   ad80305_tx_sched #(
      .RATE_DIV(RATE_DIV), .FLUSH_CYC(FLUSH_CYC), .SETTLE_CYC(SETTLE_CYC), .PREFILL(PREFILL)
   ) dut (
      .i_fpga_clk(clk), .i_fpga_rst(rst_n), .i_tx_en(tx_en), .i_src_sel(src),
      .i_bb_idata(bi), .i_bb_qdata(bq), .i_fifo_wrfull(wrfull), .i_fifo_rdempty(rdempty),
      .o_fifo_aclr(aclr), .o_fifo_wrreq(wrreq), .o_fifo_data(data), .o_state(st),
      .o_running(running), .o_ovf_cnt(ovf), .o_unf_cnt(unf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference word for the next write from the currently applied source and the model ramp
   function automatic logic [23:0] model_word(input logic [1:0] s, input logic [11:0] i, input logic [11:0] q);
      case (s)
         2'd0:    return {q, i};
         2'd1:    return {~m_ramp, m_ramp};
         default: return 24'h0;
      endcase
   endfunction

   task automatic wait_wr(input int maxc, output logic [23:0] d, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!wrreq && cyc < maxc);
      if (!wrreq) cyc = -1;
      d = data;
   endtask

   task automatic expect_write(input string tag, input int gap);
      logic [23:0] exp, d;
      int cyc;
      exp = model_word(src, bi, bq);
      wait_wr(gap + 2 * RATE_DIV, d, cyc);
      check({tag, " gap"}, 32'(cyc), 32'(gap));
      check({tag, " data"}, 32'(d), 32'(exp));
      if (src == 2'd1) m_ramp = m_ramp + 12'd1;
   endtask

   task automatic count_state(input logic [2:0] s, output int n);
      n = 0;
      while (st === s && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic flush_settle(input string tag);
      int n;
      m_ramp = 12'd0;
      check({tag, " flush aclr"}, 32'(aclr), 32'd1);
      count_state(3'd1, n);
      check({tag, " flush len"}, 32'(n), 32'(FLUSH_CYC));
      check({tag, " settle aclr"}, 32'(aclr), 32'd0);
      count_state(3'd2, n);
      check({tag, " settle len"}, 32'(n), 32'(SETTLE_CYC));
      check({tag, " prefill st"}, 32'(st), 32'd3);
   endtask

   task automatic prefill(input string tag);
      for (int k = 0; k < PREFILL; k++) expect_write({tag, " prefill"}, RATE_DIV);
      check({tag, " run st"}, 32'(st), 32'd4);
      check({tag, " running"}, 32'(running), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " st"}, 32'(st), 32'd0);
      check({tag, " aclr"}, 32'(aclr), 32'd1);
      check({tag, " wrreq"}, 32'(wrreq), 32'd0);
      check({tag, " data"}, 32'(data), 32'd0);
      check({tag, " running"}, 32'(running), 32'd0);
      check({tag, " ovf"}, 32'(ovf), 32'd0);
      check({tag, " unf"}, 32'(unf), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] d;
      int cyc, n;
      logic [15:0] exp_ovf;

      // 1. reset values and bring-up with ramp source
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("idle hold", 32'(st), 32'd0);
      src = 2'd1;
      tx_en = 1'b1;
      @(negedge clk);
      check("t1 enter flush", 32'(st), 32'd1);
      flush_settle("t1");
      prefill("t1");
      repeat (3) expect_write("t1 ramp", RATE_DIV);

      // 2. source selection with random traffic, mid-interval switch, ramp wrap
      src = 2'd0; bi = 12'h123; bq = 12'hABC;
      expect_write("t2 bb", RATE_DIV);
      repeat (40) begin
         src = 2'($urandom_range(0, 3));
         bi = 12'($urandom);
         bq = 12'($urandom);
         expect_write("t2 rand", RATE_DIV);
      end
      src = 2'd0; bi = 12'h5A5; bq = 12'h3C3;
      expect_write("t2 pre switch", RATE_DIV);
      repeat (2) begin
         @(negedge clk);
         check("t2 no glitch", 32'(wrreq), 32'd0);
      end
      src = 2'd2;
      expect_write("t2 switch zero", RATE_DIV - 2);
      src = 2'd1;
      repeat (4100) expect_write("t2 ramp wrap", RATE_DIV);

      // 3. overflow in RUN
      wrfull = 1'b1;
      for (int i = 0; i < RATE_DIV; i++) begin
         @(negedge clk);
         check("t3 suppressed", 32'(wrreq), 32'd0);
      end
      check("t3 st", 32'(st), 32'd1);
      check("t3 ovf", 32'(ovf), 32'd1);
      check("t3 running", 32'(running), 32'd0);
      wrfull = 1'b0;
      flush_settle("t3");
      prefill("t3");

      // 4. underflow in RUN, ignored rising edge during SETTLE
      rdempty = 1'b1;
      repeat (3) @(negedge clk);
      check("t4 st", 32'(st), 32'd1);
      check("t4 unf", 32'(unf), 32'd1);
      rdempty = 1'b0;
      m_ramp = 12'd0;
      count_state(3'd1, n);
      check("t4 flush len", 32'(n), 32'(FLUSH_CYC));
      rdempty = 1'b1;
      repeat (5) @(negedge clk);
      rdempty = 1'b0;
      count_state(3'd2, n);
      check("t4 settle len", 32'(n), 32'(SETTLE_CYC - 5));
      check("t4 settle unf", 32'(unf), 32'd1);
      prefill("t4");
      check("t4 unf hold", 32'(unf), 32'd1);

      // 5. tx_en drop in RUN and in PREFILL (coincident with strobe), then async reset mid-RUN
      @(negedge clk);
      tx_en = 1'b0;
      @(negedge clk);
      check("t5 run idle", 32'(st), 32'd0);
      check("t5 run aclr", 32'(aclr), 32'd1);
      check("t5 run running", 32'(running), 32'd0);
      wait_wr(12, d, cyc);
      check("t5 run no wr", 32'(cyc), 32'hFFFF_FFFF);
      tx_en = 1'b1;
      @(negedge clk);
      check("t5 reenter flush", 32'(st), 32'd1);
      flush_settle("t5");
      repeat (2) expect_write("t5 prefill", RATE_DIV);
      repeat (3) @(negedge clk);
      tx_en = 1'b0;
      @(negedge clk);
      check("t5 pf idle", 32'(st), 32'd0);
      check("t5 pf wrreq", 32'(wrreq), 32'd0);
      check("t5 pf aclr", 32'(aclr), 32'd1);
      wait_wr(12, d, cyc);
      check("t5 pf no wr", 32'(cyc), 32'hFFFF_FFFF);
      tx_en = 1'b1;
      @(negedge clk);
      flush_settle("t5b");
      prefill("t5b");
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("t5 async rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5 post rst flush", 32'(st), 32'd1);
      flush_settle("t5c");
      prefill("t5c");

      // 6. simultaneous overflow and underflow, then counter saturation
      @(negedge clk);
      rdempty = 1'b1;
      wrfull = 1'b1;
      repeat (3) @(negedge clk);
      check("t6 both st", 32'(st), 32'd1);
      check("t6 both ovf", 32'(ovf), 32'd1);
      check("t6 both unf", 32'(unf), 32'd1);
      check("t6 both wrreq", 32'(wrreq), 32'd0);
      wrfull = 1'b0;
      rdempty = 1'b0;
      flush_settle("t6");
      prefill("t6");
      force dut.ovf_cnt = 16'hFFFD;
      @(negedge clk);
      release dut.ovf_cnt;
      check("t6 preload", 32'(ovf), 32'h0000_FFFD);
      wrfull = 1'b1;
      exp_ovf = 16'hFFFD;
      repeat (3) begin
         n = 0;
         while (st === 3'd1 && n < 400) begin n++; @(negedge clk); end
         while (st !== 3'd1 && n < 400) begin n++; @(negedge clk); end
         check("t6 sat reached", 32'(st), 32'd1);
         if (exp_ovf != 16'hFFFF) exp_ovf = exp_ovf + 16'd1;
         check("t6 sat ovf", 32'(ovf), 32'(exp_ovf));
      end
      check("t6 sat unf", 32'(unf), 32'd1);
      wrfull = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ad80305_tx_sched.md
Name: ad80305_tx_sched

Overview:
Sequencing and source-arbitration controller for the AD80305 TX LVCMOS DDR path. It sits in the i_fpga_clk domain ahead of the TX clock-crossing FIFO and drives that FIFO's aclr, wrreq and 24-bit write data. It selects between baseband, internal ramp and zero IQ sources, and paces writes at one per RATE_DIV clocks. It runs the bring-up sequence (flush, settle, prefill) and recovers automatically from FIFO overflow or underflow.

Parameters:
RATE_DIV, 4, fpga clocks per FIFO write (2..16)
FLUSH_CYC, 8, cycles o_fifo_aclr is held high per flush (1..255)
SETTLE_CYC, 64, idle cycles after flush before writing (1..1023)
PREFILL, 4, FIFO words written before declaring RUN (1..15)

Ports:
i_fpga_clk  in  1  system clock
i_fpga_rst  in  1  async active-low reset
i_tx_en  in  1  software TX enable, level
i_src_sel  in  2  0=baseband, 1=ramp, 2/3=zero
i_bb_idata  in  12  baseband I
i_bb_qdata  in  12  baseband Q
i_fifo_wrfull  in  1  FIFO write-side full (i_fpga_clk domain)
i_fifo_rdempty  in  1  FIFO read-side empty (i_tx_clk domain, async)
o_fifo_aclr  out  1  FIFO async clear, active high
o_fifo_wrreq  out  1  FIFO write strobe
o_fifo_data  out  24  {Q[11:0], I[11:0]}
o_state  out  3  0 IDLE, 1 FLUSH, 2 SETTLE, 3 PREFILL, 4 RUN
o_running  out  1  high in RUN
o_ovf_cnt  out  16  overflow events, saturating at 16'hFFFF
o_unf_cnt  out  16  underflow events, saturating at 16'hFFFF

Behaviour:
- Reset: i_fpga_rst low is an asynchronous reset. Reset values: state IDLE, o_fifo_aclr=1, o_fifo_wrreq=0, o_fifo_data=0, o_running=0, both counters 0, ramp=0, pace counter=0.
- rdempty is synchronised through 2 flops (reset value 1). An underflow event is a rising edge of the synchronised signal while in RUN.
- Pace counter: counts 0..RATE_DIV-1, then wraps to 0. It runs only in PREFILL and RUN and is forced to 0 in every other state. strobe = (count == RATE_DIV-1).
- FSM:
  - IDLE: aclr=1. When i_tx_en=1, go to FLUSH.
  - FLUSH: aclr=1 for exactly FLUSH_CYC cycles, then go to SETTLE.
  - SETTLE: aclr=0. Wait SETTLE_CYC cycles, then go to PREFILL.
  - PREFILL: write on each strobe. After the PREFILL-th write, go to RUN.
  - RUN: write on each strobe.
- Overflow: in PREFILL or RUN, a strobe with i_fifo_wrfull=1 suppresses that write, increments o_ovf_cnt and goes to FLUSH.
- Underflow: an underflow event in RUN increments o_unf_cnt and goes to FLUSH.
- If overflow and underflow occur in the same cycle, both counters increment and a single flush is performed.
- i_tx_en=0 forces IDLE on the next clock from any state and overrides all other transitions. wrreq is 0 from that edge onward.
- Write timing: o_fifo_wrreq is a registered 1-cycle pulse on the clock after a strobe. o_fifo_data is registered on the same edge and holds until the next write.
- Source selection: i_src_sel is sampled only at the strobe, so a source switch takes effect on a write boundary.
  - Baseband: {i_bb_qdata, i_bb_idata}.
  - Ramp: I=ramp, Q=~ramp. ramp increments by 1 per write (12-bit wrap 4095 -> 0), is cleared on entering FLUSH, and is held while a different source is selected.
  - Zero: 24'h0.
- o_running = (state == RUN), registered.
- Counters clear only on reset.

Test Plan:
1. Reset, then i_tx_en=1, src=1, defaults, full=0, rdempty=0 -> aclr high for exactly 8 cycles, 64 settle cycles, then wrreq every 4th cycle with data 24'hFFF000, 24'hFFE001, ... State is RUN after the 4th write.
2. In RUN with src=0 and I=12'h123, Q=12'hABC -> o_fifo_data = 24'hABC123 on the next wrreq. Switching src to 2 mid-interval -> the next write is 0, with no partial or glitched write.
3. In RUN, hold wrfull=1 across a strobe -> no wrreq, o_ovf_cnt=1, state FLUSH, aclr high for 8 cycles, then the full sequence restarts and the ramp restarts at 0.
4. In RUN, pulse rdempty 0->1 -> within 3 cycles o_unf_cnt=1 and state FLUSH. A rising rdempty during SETTLE -> no count.
5. Drop i_tx_en in PREFILL and in RUN -> state IDLE on the next clock, aclr=1, no further wrreq. Assert i_fpga_rst mid-RUN -> all outputs at reset values immediately.
6. Force 65536 overflows (or preload the counter) -> o_ovf_cnt stays at 16'hFFFF. Apply simultaneous overflow and underflow -> both counters +1 and one FLUSH period.
